// File: rtl/seven_segment_scan_decoder.sv
// Passive monitor for a multiplexed six-digit HH:MM:SS seven-segment display bus.
// Each scanned digit is captured once it has settled. Its glyph is decoded back to
// BCD, and complete frames are reported as binary hour/minute/second values.
//
// Ports:
//   clk                      system clock, rising edge
//   reset                    synchronous, active-high reset
//   seven_segment_indicators digit selects, bit 5 = hour tens ... bit 0 = second units
//   digit                    segment byte {dp,g,f,e,d,c,b,a}
//   hour/minute/second       last valid frame, binary
//   dp_mask                  decimal points of the last valid frame, per position
//   frame_valid              pulse: range-checked frame loaded into the outputs
//   frame_changed            pulse with frame_valid when the time differs from the previous frame
//   frame_error              pulse: completed frame had a bad glyph or an out-of-range value
//   stale                    no capture for TIMEOUT_CYCLES (or no valid frame since reset)
module seven_segment_scan_decoder #(
    parameter int unsigned SETTLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter bit          SEL_ACTIVE_LOW = 1'b1,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] seven_segment_indicators,
    input  logic [7:0] digit,
    output logic [7:0] hour,
    output logic [7:0] minute,
    output logic [7:0] second,
    output logic [5:0] dp_mask,
    output logic       frame_valid,
    output logic       frame_changed,
    output logic       frame_error,
    output logic       stale
);

    localparam int unsigned NPOS   = 6;
    localparam int unsigned SEG_W  = 8;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HELD   = 2'd2
    } state_t;

    // Input registers and polarity normalisation (1 = active select, 1 = lit segment)
    logic [NPOS-1:0]  sel_q;
    logic [SEG_W-1:0] seg_q;
    logic [NPOS-1:0]  sel_n;
    logic [SEG_W-1:0] seg_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            sel_q <= '0;
            seg_q <= '0;
        end else begin
            sel_q <= seven_segment_indicators;
            seg_q <= digit;
        end
    end

    assign sel_n = SEL_ACTIVE_LOW ? ~sel_q : sel_q;
    assign seg_n = SEG_ACTIVE_LOW ? ~seg_q : seg_q;

    // Glyph decode on g..a: returns {invalid, value}
    function automatic logic [4:0] decode_glyph(input logic [6:0] s);
        logic [4:0] r;
        r = {1'b1, 4'd0};
        case (s)
            7'h3F:        r = {1'b0, 4'd0};
            7'h06:        r = {1'b0, 4'd1};
            7'h5B:        r = {1'b0, 4'd2};
            7'h4F:        r = {1'b0, 4'd3};
            7'h66:        r = {1'b0, 4'd4};
            7'h6D:        r = {1'b0, 4'd5};
            7'h7D:        r = {1'b0, 4'd6};
            7'h07, 7'h27: r = {1'b0, 4'd7};
            7'h7F:        r = {1'b0, 4'd8};
            7'h6F, 7'h67: r = {1'b0, 4'd9};
            default:      r = {1'b1, 4'd0};
        endcase
        return r;
    endfunction

    logic [4:0] dec_c;
    assign dec_c = decode_glyph(seg_n[6:0]);

    // Capture FSM
    state_t           state, state_d;
    logic [NPOS-1:0]  smp_sel, smp_sel_d;
    logic [SEG_W-1:0] smp_seg, smp_seg_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             onehot_c;
    logic             same_c;
    logic             capture_c;
    logic             load_c;
    logic [CNT_W:0]   cnt_inc;

    assign onehot_c = (sel_n != '0) && ((sel_n & (sel_n - NPOS'(1))) == '0);
    assign same_c   = (sel_n == smp_sel) && (seg_n == smp_seg);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_WAIT;
            smp_sel <= '0;
            smp_seg <= '0;
            cnt     <= '0;
        end else begin
            state   <= state_d;
            smp_sel <= smp_sel_d;
            smp_seg <= smp_seg_d;
            cnt     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state;
        smp_sel_d = smp_sel;
        smp_seg_d = smp_seg;
        cnt_d     = cnt;
        capture_c = 1'b0;
        load_c    = 1'b0;
        cnt_inc   = (CNT_W+1)'(cnt) + (CNT_W+1)'(1);

        case (state)
            ST_WAIT: begin
                if (onehot_c) load_c = 1'b1;
            end
            ST_SETTLE: begin
                if (!onehot_c) begin
                    state_d = ST_WAIT;
                end else if (same_c) begin
                    cnt_d = cnt_inc[CNT_W-1:0];
                    if (cnt_inc == (CNT_W+1)'(SETTLE_CYCLES)) begin
                        capture_c = 1'b1;
                        state_d   = ST_HELD;
                    end
                end else begin
                    load_c = 1'b1;
                end
            end
            ST_HELD: begin
                if (!onehot_c) begin
                    state_d = ST_WAIT;
                end else if (!same_c) begin
                    load_c = 1'b1;
                end
            end
            default: state_d = ST_WAIT;
        endcase

        // A new one-hot sample counts as the first settle sample
        if (load_c) begin
            smp_sel_d = sel_n;
            smp_seg_d = seg_n;
            cnt_d     = CNT_W'(1);
            if (SETTLE_CYCLES == 1) begin
                capture_c = 1'b1;
                state_d   = ST_HELD;
            end else begin
                state_d = ST_SETTLE;
            end
        end
    end

    // Idle counter: restarts on capture, saturates at the timeout
    logic [IDLE_W-1:0] idle, idle_d;
    logic              timeout_c;

    always_comb begin
        if (capture_c) begin
            idle_d = '0;
        end else if (idle == IDLE_W'(TIMEOUT_CYCLES)) begin
            idle_d = idle;
        end else begin
            idle_d = idle + IDLE_W'(1);
        end
    end

    assign timeout_c = (idle_d == IDLE_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk) begin
        if (reset) idle <= '0;
        else       idle <= idle_d;
    end

    // Position slots and seen bits
    logic [3:0]      slot_val [NPOS];
    logic [NPOS-1:0] slot_dp;
    logic [NPOS-1:0] slot_bad;
    logic [NPOS-1:0] seen, seen_d;
    logic            frame_done_c;

    assign frame_done_c = (seen == '1);

    always_comb begin
        seen_d = seen;
        if (frame_done_c || timeout_c) seen_d = '0;
        if (capture_c) seen_d = seen_d | sel_n;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            seen     <= '0;
            slot_dp  <= '0;
            slot_bad <= '0;
            for (int i = 0; i < NPOS; i++) slot_val[i] <= '0;
        end else begin
            seen <= seen_d;
            if (capture_c) begin
                for (int i = 0; i < NPOS; i++) begin
                    if (sel_n[i]) begin
                        slot_val[i] <= dec_c[3:0];
                        slot_dp[i]  <= seg_n[7];
                        slot_bad[i] <= dec_c[4];
                    end
                end
            end
        end
    end

    // Frame evaluation stage
    logic [7:0] hour_c, minute_c, second_c;
    logic       frame_err_c;

    assign hour_c   = 8'(slot_val[5]) * 8'd10 + 8'(slot_val[4]);
    assign minute_c = 8'(slot_val[3]) * 8'd10 + 8'(slot_val[2]);
    assign second_c = 8'(slot_val[1]) * 8'd10 + 8'(slot_val[0]);

    assign frame_err_c = (|slot_bad) || (slot_val[5] > 4'd2) || (hour_c > 8'd23) ||
                         (slot_val[3] > 4'd5) || (slot_val[1] > 4'd5);

    logic       eval_pend;
    logic       eval_err;
    logic [7:0] eval_h, eval_m, eval_s;
    logic [5:0] eval_dp;

    always_ff @(posedge clk) begin
        if (reset) begin
            eval_pend <= 1'b0;
            eval_err  <= 1'b0;
            eval_h    <= '0;
            eval_m    <= '0;
            eval_s    <= '0;
            eval_dp   <= '0;
        end else begin
            eval_pend <= frame_done_c;
            if (frame_done_c) begin
                eval_err <= frame_err_c;
                eval_h   <= hour_c;
                eval_m   <= minute_c;
                eval_s   <= second_c;
                eval_dp  <= slot_dp;
            end
        end
    end

    // Output stage
    logic have_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            hour          <= '0;
            minute        <= '0;
            second        <= '0;
            dp_mask       <= '0;
            frame_valid   <= 1'b0;
            frame_changed <= 1'b0;
            frame_error   <= 1'b0;
            stale         <= 1'b1;
            have_valid    <= 1'b0;
        end else begin
            frame_valid   <= 1'b0;
            frame_changed <= 1'b0;
            frame_error   <= 1'b0;
            if (eval_pend) begin
                if (eval_err) begin
                    frame_error <= 1'b1;
                end else begin
                    hour          <= eval_h;
                    minute        <= eval_m;
                    second        <= eval_s;
                    dp_mask       <= eval_dp;
                    frame_valid   <= 1'b1;
                    frame_changed <= !have_valid || (eval_h != hour) ||
                                     (eval_m != minute) || (eval_s != second);
                    have_valid    <= 1'b1;
                end
            end
            // Stale holds after reset until a valid frame; later any capture clears it
            if (timeout_c) begin
                stale <= 1'b1;
            end else if (eval_pend && !eval_err) begin
                stale <= 1'b0;
            end else if (capture_c && have_valid) begin
                stale <= 1'b0;
            end
        end
    end

endmodule

// File: doc/seven_segment_scan_decoder.md
Name: seven_segment_scan_decoder

Overview:
- Passive monitor on the multiplexed six-digit display bus: digit-select lines plus shared 8-bit segment byte.
- Captures each scanned digit once it has settled and decodes the segment pattern back to BCD.
- Assembles complete HH:MM:SS frames and reports them as binary values with valid, change and error flags.
- Used as the on-chip self-check and bench monitor that reads what the display driver writes.

Parameters:
SETTLE_CYCLES, 4, consecutive identical samples (select and segments) required before a digit is captured; range 1..255
TIMEOUT_CYCLES, 100000, cycles without any capture before the decoder declares the display stale
SEL_ACTIVE_LOW, 1, 1 = a select line is active when 0
SEG_ACTIVE_LOW, 1, 1 = a segment is lit when 0

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
seven_segment_indicators  input  6  digit selects; bit 5 = hour tens ... bit 0 = second units
digit  input  8  segments {dp,g,f,e,d,c,b,a}
hour  output  8  decoded hour, binary 0..23
minute  output  8  decoded minute, binary 0..59
second  output  8  decoded second, binary 0..59
dp_mask  output  6  decimal-point state per position from the last complete frame
frame_valid  output  1  one-cycle pulse: a range-checked frame was loaded into hour/minute/second
frame_changed  output  1  one-cycle pulse coincident with frame_valid when the new time differs from the previous valid frame
frame_error  output  1  one-cycle pulse: a completed frame contained an undecodable glyph or an out-of-range value
stale  output  1  high when no capture has occurred for TIMEOUT_CYCLES

Behaviour:
- Input handling: both buses are registered once. Polarity is then normalised per the parameters, so that 1 = active select and 1 = lit segment.
- Glyph decode uses segments g..a only:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111.
  - 7 also accepts 0100111; 9 also accepts 1101111 with or without segment d.
  - Any other pattern, including blank, is invalid.
- Capture FSM states WAIT, SETTLE, HELD:
  - WAIT: select not one-hot (zero or more than one bit). No capture. A one-hot select loads the sample, settle count = 1, and moves to SETTLE.
  - SETTLE: an identical sample increments the count; on reaching SETTLE_CYCLES, capture {glyph, dp, invalid flag} into that position's slot, set its seen bit, go to HELD. A differing one-hot sample reloads with count = 1. A non-one-hot sample goes to WAIT.
  - HELD: stays until the sample changes; then it behaves as WAIT or SETTLE accordingly. A position is captured once per scan dwell.
  - With SETTLE_CYCLES=1, capture happens in the first registered cycle.
- Recapture of an already-seen position before the frame completes overwrites that slot.
- Frame completion: the cycle after seen==6'b111111, evaluate the frame and clear all seen bits.
  - Error if any slot is invalid, hour tens >2, hour >23, minute tens >5, or second tens >5. Then pulse frame_error; hour/minute/second and dp_mask are unchanged.
  - Otherwise load hour = 10*tens+units (likewise minute and second), load dp_mask, and pulse frame_valid. Pulse frame_changed if any of hour/minute/second differs from the previous value, and on the first valid frame after reset.
- Latency: output updates 2 cycles after the capture that completes the frame (evaluate + register).
- Stale handling:
  - The idle counter resets on every capture.
  - When it reaches TIMEOUT_CYCLES, stale=1 and the seen bits clear; the counter saturates.
  - The next capture clears stale.
- Reset (synchronous, mid-operation included): FSM to WAIT, counters 0, seen 0. hour/minute/second 0, dp_mask 0, all pulses 0, stale 1 until the first valid frame.
- No back-pressure. Pulses are never stretched, and a new frame cannot complete within 6 captures of the previous one.

Test Plan:
- Scan "12:34:56" active-low, 8 cycles per digit, SETTLE_CYCLES=4 -> one frame_valid with hour=12, minute=34, second=56, frame_changed=1. A second identical scan -> frame_valid=1, frame_changed=0.
- Scan "25:00:00" -> frame_error pulse, hour/minute/second hold previous values, frame_valid=0. Same result with segment pattern 1010101 in the minute-units slot.
- Digit dwell of 3 cycles with SETTLE_CYCLES=4 -> no captures and no frame. Ghost cycles with select=6'b000011 between digits -> ignored, frame decodes correctly.
- TIMEOUT_CYCLES=64, stop scanning after 3 digits -> stale rises exactly 64 cycles after the last capture; resuming with a full scan clears stale and yields a valid frame.
- Assert reset after 4 of 6 digits -> outputs 0, stale=1. The following 2 digits alone produce no frame; the next full scan "23:59:59" -> hour=23, minute=59, second=59.
- dp lit on positions 3 and 1 during a scan of "00:00:09" -> dp_mask=6'b001010, second=9.
